// File: rtl/int2flt_pkg.sv
// Shared types and constants for the 16-bit integer to half-precision converter.
package int2flt_pkg;

    localparam int INT_W = 16;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } half_t;

    // Magnitude of a two's-complement word; -32768 maps to 16'h8000.
    function automatic logic [INT_W-1:0] mag_of(input logic [INT_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/int2flt_norm.sv
// Left-shifting normaliser: shifts the magnitude until its MSB is set, counting shifts.
module int2flt_norm
    import int2flt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [INT_W-1:0] mag_in,
    input  logic             shift_en,
    output logic             norm_done,
    output logic [INT_W-1:0] mag_out,
    output logic [3:0]       s
);

    logic [INT_W-1:0] mag;
    logic [3:0]       cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag <= '0;
            cnt <= '0;
        end else if (load) begin
            mag <= mag_in;
            cnt <= '0;
        end else if (shift_en && !mag[INT_W-1]) begin
            mag <= mag << 1;
            cnt <= cnt + 4'd1;
        end
    end

    assign norm_done = mag[INT_W-1];
    assign mag_out   = mag;
    assign s         = cnt;

endmodule

// File: rtl/int2flt_seq.sv
// Multi-cycle int16 -> IEEE-754 half converter with Start/Done handshake; truncates, never rounds.
module int2flt_seq
    import int2flt_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [INT_W-1:0] Int_In,
    output logic [INT_W-1:0] Flt_Out,
    output logic             Done,
    output logic             Busy
);

    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + INT_W - 1);

    state_t           state, state_nxt;
    logic [INT_W-1:0] int_q;
    logic             sign_q;
    logic             done_q;
    half_t            flt_q;

    logic [INT_W-1:0] abs_mag;
    logic             norm_done;
    logic [INT_W-1:0] mag_out;
    logic [3:0]       s;

    assign abs_mag = mag_of(int_q, sign_q);

    int2flt_norm u_norm (
        .clk       (Clk),
        .reset     (Reset),
        .load      (state == ABS),
        .mag_in    (abs_mag),
        .shift_en  (state == NORM),
        .norm_done (norm_done),
        .mag_out   (mag_out),
        .s         (s)
    );

    // NOTE: the default assignment before the case keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (Start) state_nxt = ABS;
            ABS:        state_nxt = (abs_mag == '0) ? PACK : NORM;
            NORM:       if (norm_done) state_nxt = PACK;
            PACK:       state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            int_q  <= '0;
            sign_q <= 1'b0;
            done_q <= 1'b0;
            flt_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        int_q  <= Int_In;
                        sign_q <= Int_In[INT_W-1];
                        done_q <= 1'b0;
                    end
                end
                PACK: begin
                    // Zero is forced to +0 so a negative sign never leaks into a zero result.
                    if (mag_out == '0) begin
                        flt_q <= '0;
                    end else begin
                        flt_q.sign <= sign_q;
                        flt_q.exp  <= EXP_TOP - EXP_W'(s);
                        flt_q.frac <= mag_out[INT_W-2 -: MAN_W];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Flt_Out = flt_q;
    assign Done    = done_q;
    assign Busy    = (state == ABS) || (state == NORM) || (state == PACK);

endmodule

// File: doc/int2flt_seq.md
Name: int2flt_seq

Overview:
- Multi-cycle converter from 16-bit two's-complement integer to IEEE-754 half precision (1 sign, 5 exponent, 10 fraction bits, bias 15).
- Sits directly upstream of the float-to-integer stage; its Flt_Out word is that stage's input.
- Uses the same Start/Done handshake as Top.
- Truncates and never rounds, matching the no-round float-to-int flow.

Parameters:
- INT_W, 16, integer input width (fixed; other values unsupported).
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored fraction width.
- BIAS, 15, exponent bias.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled on the rising edge while idle.
- Int_In  in  16  two's-complement operand; captured on the edge where Start is accepted.
- Flt_Out  out  16  half-precision result {sign, exp[4:0], frac[9:0]}.
- Done  out  1  result valid; high from completion until the next accepted Start.
- Busy  out  1  high while a conversion is in progress (states ABS, NORM, PACK).

Behaviour:
- Reset: state IDLE, Flt_Out=16'h0000, Done=0, Busy=0, internal mag/shift count cleared. Reset has priority over Start and aborts any conversion in flight, with no partial result exposed.
- States: IDLE, ABS, NORM, PACK, DONE.
- IDLE or DONE with Start=1: latch Int_In and sign=Int_In[15], clear Done, go to ABS. Start in DONE restarts immediately.
- ABS: mag = sign ? -Int_In : Int_In, held as 16-bit unsigned, so -32768 gives 16'h8000. Next state is PACK if mag==0, else NORM.
- NORM: one action per edge.
  - mag[15]==0: shift mag left by 1 and increment the 4-bit count s.
  - mag[15]==1: go to PACK without shifting.
- PACK: Flt_Out = {sign, 5'(30 - s), mag[14:5]}. If mag==0, Flt_Out = 16'h0000 (no negative zero). Set Done=1, go to DONE.
- DONE: hold Flt_Out and Done. Return to ABS on Start.
- Latency, counted from the accepting edge E0:
  - Done is high after edge E0+s+3, where s = 15 - (index of the leading one).
  - Worst case is operand 1: Done after E0+18.
  - Zero: Done after E0+2.
- Start while Busy is ignored, and Int_In changes while Busy are ignored.
- Flt_Out keeps its previous value until PACK, then is stable while Done=1.
- Rounding: bits mag[4:0] after normalisation are discarded, which truncates toward zero in magnitude.
- Range: every 16-bit input is representable (maximum exponent 30), so there is no overflow or infinity path.

Decomposition:
- Package int2flt_pkg holds:
  - state enum state_t {IDLE, ABS, NORM, PACK, DONE};
  - localparams INT_W, EXP_W, MAN_W, BIAS;
  - typedef half_t, a packed struct {sign, exp, frac}.
- One sub-module is natural: int2flt_norm. It holds the shift register and leading-one counter with ports load, mag_in, shift_en, norm_done, mag_out, s. The FSM and packing stay in int2flt_seq.

Test Plan:
- Reset held 2 cycles, then Int_In=0 with Start pulse -> Flt_Out=16'h0000, Done high after 2 edges, Busy low afterwards.
- Int_In=1 -> Flt_Out=16'h3C00 with Done after exactly 18 edges. Int_In=-1 -> 16'hBC00.
- Int_In=3 -> 16'h4200. Int_In=1000 -> 16'h63D0. Int_In=32767 -> 16'h77FF (truncated, not rounded to 16'h7800).
- Int_In=-32768 -> 16'hF800 with Done after 3 edges. Feed each result into the float-to-int stage and check the round trip returns -32768.
- Start and a new Int_In asserted while Busy -> ignored, original result delivered. Start during DONE -> Done drops next edge and the new conversion runs.
- Reset asserted mid-NORM on a 1000 conversion -> next edge IDLE, Done=0, Flt_Out=0. A following Start with Int_In=5 -> 16'h4500.
